fir_output_stage: RTL and testbench
===================================

// Module: fir_output_stage
// PURPOSE
//  Downstream stage of the pipelined FIR MAC. Captures each FIR_out word flagged by in_valid,
//  rounds and saturates it to OUT_WIDTH bits, and holds the results in a DEPTH-entry FIFO.
//  Results leave through a valid/ready handshake, which decouples the fixed-rate filter from a
//  consumer that can stall (display driver, UART packer).
// PARAMETERS
//  IN_WIDTH   14  width of the FIR result; equals Sample_size + weight_size + 3 of the MAC
//  OUT_WIDTH  8   width of the rounded, saturated output word
//  SHIFT      3   right shift (scale-down) applied before saturation; must be >= 1
//  DEPTH      4   FIFO entries; power of two, >= 2
//  CNT_W      3   width of the occupancy count; equals log2(DEPTH)+1
// PORTS
//  clock      in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high; clears all state
//  fir_in     in   IN_WIDTH   unsigned FIR result from the MAC
//  in_valid   in   1          fir_in is a new result this cycle
//  out_data   out  OUT_WIDTH  head-of-FIFO word
//  out_valid  out  1          out_data is valid
//  out_ready  in   1          consumer accepts out_data this cycle
//  sat_flag   out  1          out_data was saturated; travels with the word
//  overflow   out  1          sticky: a result was dropped because the FIFO was full
//  count      out  CNT_W      current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, sat_flag=0, overflow=0, count=0; pointers=0; stage-1 reg empty.
//    Reset asserted mid-operation discards all queued words immediately (async).
//  Stage 1, registered on the cycle after in_valid:
//    r = (fir_in + 2^(SHIFT-1)) >> SHIFT, computed IN_WIDTH+1 bits wide so the add cannot wrap.
//    If r > 2^OUT_WIDTH-1: word = all ones, sat = 1. Otherwise word = r[OUT_WIDTH-1:0], sat = 0.
//    The stage-1 valid bit follows in_valid delayed by 1 cycle.
//  Stage 2, FIFO write: when the stage-1 valid bit is set, {sat, word} is written at wr_ptr.
//  Latency: in_valid at edge n -> word in FIFO and out_valid=1 after edge n+2 when the FIFO was empty.
//    Empty FIFO has no combinational bypass.
//  Read: a word pops when out_valid && out_ready at the rising edge.
//    out_data and sat_flag always show the head entry and hold stable while out_valid && !out_ready.
//  Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH); out_valid = (count != 0).
//    EMPTY   + write                   -> PARTIAL (or FULL if DEPTH==1; excluded by the DEPTH >= 2 rule)
//    PARTIAL + write xor pop           -> count +/-1, becomes FULL or EMPTY at the limits
//    write && pop the same cycle       -> count unchanged; both pointers advance
//    FULL    + write && pop            -> write accepted, count stays DEPTH
//    FULL    + write && !pop           -> word dropped, overflow <= 1 (sticky until reset), FIFO unchanged
//    EMPTY   + out_ready               -> no effect; count never underflows
//  Pointers: log2(DEPTH) bits; they wrap from DEPTH-1 to 0 with no gap or duplicate.
//  The block never back-pressures the MAC: no ready output; loss is signalled only by overflow.
//  Every output is registered or decoded from registered state; out_ready -> out_* has no
//    combinational path.
// TESTING
//  1 reset, then fir_in=100 pulsed once with out_ready=1 -> out_valid after 2 edges, out_data=13,
//    sat_flag=0, count returns to 0 after the pop.
//  2 rounding edge: fir_in=3 -> 0; fir_in=4 -> 1; fir_in=12 -> 2; fir_in=0 -> 0.
//  3 saturation: fir_in=2047 -> 255, sat_flag=1; fir_in=16383 -> 255, sat_flag=1, no wrap to small values.
//  4 out_ready=0, six back-to-back inputs 8,16,24,32,40,48 -> count=4, overflow=1;
//    then out_ready=1 -> pops 1,2,3,4 in order; 5 and 6 are lost.
//  5 FIFO full, in_valid and out_ready asserted the same cycle -> count stays 4, overflow stays 0,
//    order preserved across pointer wrap.
//  6 reset asserted between clock edges with count=3 -> out_valid=0, count=0 and overflow=0 at once;
//    normal operation resumes on the next input.

Source files
------------

// File: rtl/fir_output_stage.sv
// fir_output_stage
//   Output stage behind the pipelined FIR MAC.
//   - Each fir_in word flagged by in_valid is registered one cycle later.
//   - On that edge it is rounded, scaled down by SHIFT and saturated to OUT_WIDTH.
//   - Results queue in a DEPTH-entry FIFO drained through a valid/ready handshake.
//   - The MAC is never stalled. A word that arrives while the FIFO is full and
//     nothing is popping is dropped, and the sticky overflow flag is set.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset, clears all state and queued words
//   fir_in     unsigned FIR result (IN_WIDTH)
//   in_valid   fir_in carries a new result this cycle
//   out_data   head-of-FIFO word (OUT_WIDTH)
//   out_valid  out_data is valid (FIFO not empty)
//   out_ready  consumer takes out_data at this rising edge
//   sat_flag   head word was saturated
//   overflow   sticky: a result was dropped because the FIFO was full
//   count      FIFO occupancy, 0..DEPTH
//
// Occupancy (count is the state register)
//   state   | meaning
//   EMPTY   | count == 0, out_valid low, pops ignored
//   PARTIAL | 0 < count < DEPTH, writes and pops both accepted
//   FULL    | count == DEPTH, a write is accepted only alongside a pop
module fir_output_stage #(
   parameter int IN_WIDTH  = 14,
   parameter int OUT_WIDTH = 8,
   parameter int SHIFT     = 3,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [IN_WIDTH-1:0]  fir_in,
   input  logic                 in_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sat_flag,
   output logic                 overflow,
   output logic [CNT_W-1:0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int RW    = IN_WIDTH + 1;
   localparam logic [RW-1:0]    HALF    = RW'(2 ** (SHIFT - 1));
   localparam logic [RW-1:0]    MAX_OUT = RW'(2 ** OUT_WIDTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Stage 1: round and saturate.
   // The sum is one bit wider than fir_in, so the rounding add cannot wrap.
   logic [RW-1:0]        rounded;
   logic [OUT_WIDTH-1:0] word_c;
   logic                 sat_c;

   always_comb begin
      rounded = ({1'b0, fir_in} + HALF) >> SHIFT;
      word_c  = rounded[OUT_WIDTH-1:0];
      sat_c   = 1'b0;
      if (rounded > MAX_OUT) begin
         word_c = '1;
         sat_c  = 1'b1;
      end
   end

   logic                 s1_valid;
   logic [OUT_WIDTH-1:0] s1_word;
   logic                 s1_sat;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
         s1_sat   <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_word <= word_c;
            s1_sat  <= sat_c;
         end
      end
   end

   // Stage 2: FIFO.
   // Each entry holds {sat, word}. Entries are cleared on reset so that
   // out_data reads 0 while the FIFO is empty after reset.
   logic [OUT_WIDTH:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               full;
   logic               pop;
   logic               wr_acc;

   always_comb begin
      full   = (count == FULL_CNT);
      pop    = (count != '0) && out_ready;
      // When FULL, a write is legal only because the pop frees the head slot on the same edge.
      wr_acc = s1_valid && (!full || pop);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            mem[wr_ptr] <= {s1_sat, s1_word};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (s1_valid && !wr_acc)
            overflow <= 1'b1;
         if (wr_acc && !pop)
            count <= count + CNT_W'(1);
         else if (!wr_acc && pop)
            count <= count - CNT_W'(1);
      end
   end

   // Outputs are decoded from registered state only; out_ready never reaches them combinationally.
   always_comb begin
      out_valid = (count != '0);
      out_data  = mem[rd_ptr][OUT_WIDTH-1:0];
      sat_flag  = mem[rd_ptr][OUT_WIDTH];
   end

endmodule

// File: tb/tb_fir_output_stage.sv
module tb_fir_output_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] fir_in = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        sat_flag;
   logic        overflow;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   fir_output_stage #(
      .IN_WIDTH(14), .OUT_WIDTH(8), .SHIFT(3), .DEPTH(4), .CNT_W(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .fir_in(fir_in),
      .in_valid(in_valid),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sat_flag(sat_flag),
      .overflow(overflow),
      .count(count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [13:0] fir;
      logic [7:0]  data;
      logic        sat;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [13:0] v);
      fir_in   = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      vecs[0] = '{fir: 14'd3,     data: 8'd0,   sat: 1'b0};
      vecs[1] = '{fir: 14'd4,     data: 8'd1,   sat: 1'b0};
      vecs[2] = '{fir: 14'd12,    data: 8'd2,   sat: 1'b0};
      vecs[3] = '{fir: 14'd0,     data: 8'd0,   sat: 1'b0};
      vecs[4] = '{fir: 14'd2043,  data: 8'd255, sat: 1'b0};
      vecs[5] = '{fir: 14'd2044,  data: 8'd255, sat: 1'b1};
      vecs[6] = '{fir: 14'd2047,  data: 8'd255, sat: 1'b1};
      vecs[7] = '{fir: 14'd16383, data: 8'd255, sat: 1'b1};

      // Reset state
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_sat_flag", int'(sat_flag), 0);
      tick();
      reset = 1'b0;
      tick();

      // 1: single word, consumer always ready, two-edge latency
      out_ready = 1'b1;
      push(14'd100);
      chk("t1_no_bypass", int'(out_valid), 0);
      tick();
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_data", int'(out_data), 13);
      chk("t1_sat", int'(sat_flag), 0);
      tick();
      chk("t1_count_after_pop", int'(count), 0);
      chk("t1_valid_after_pop", int'(out_valid), 0);
      out_ready = 1'b0;

      // 2/3: rounding and saturation table
      for (int i = 0; i < 8; i++) begin
         push(vecs[i].fir);
         tick();
         chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
         chk($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].data));
         chk($sformatf("vec%0d_sat", i), int'(sat_flag), int'(vecs[i].sat));
         chk($sformatf("vec%0d_count", i), int'(count), 1);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk($sformatf("vec%0d_popped", i), int'(count), 0);
      end
      chk("empty_pop_no_underflow", int'(count), 0);

      // 4: stalled consumer, six inputs, last two dropped
      for (int i = 1; i <= 6; i++) push(14'(8 * i));
      tick();
      tick();
      chk("t4_count_full", int'(count), 4);
      chk("t4_overflow", int'(overflow), 1);
      chk("t4_hold_data", int'(out_data), 1);
      tick();
      chk("t4_hold_stable", int'(out_data), 1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("t4_pop%0d", k), int'(out_data), k);
         tick();
      end
      chk("t4_drained", int'(count), 0);
      chk("t4_overflow_sticky", int'(overflow), 1);
      tick();
      chk("t4_empty_ready", int'(count), 0);
      out_ready = 1'b0;

      // 6: asynchronous reset between edges with three words queued
      push(14'd80);
      push(14'd88);
      push(14'd96);
      tick();
      chk("t6_count3", int'(count), 3);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_valid", int'(out_valid), 0);
      chk("t6_async_count", int'(count), 0);
      chk("t6_async_overflow", int'(overflow), 0);
      chk("t6_async_data", int'(out_data), 0);
      tick();
      reset = 1'b0;
      tick();
      push(14'd100);
      tick();
      chk("t6_resume_valid", int'(out_valid), 1);
      chk("t6_resume_data", int'(out_data), 13);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t6_resume_count", int'(count), 0);

      // 5: full FIFO, write and pop on the same edge, order kept across wrap
      do_reset();
      for (int i = 1; i <= 4; i++) push(14'(8 * i));
      tick();
      chk("t5_full", int'(count), 4);
      fir_in   = 14'd40;
      in_valid = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("t5_count_stays", int'(count), 4);
      chk("t5_no_overflow", int'(overflow), 0);
      for (int k = 2; k <= 5; k++) begin
         chk($sformatf("t5_order%0d", k), int'(out_data), k);
         tick();
      end
      chk("t5_drained", int'(count), 0);
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
